pipe_hazard_ctrl: RTL and testbench
===================================

# pipe_hazard_ctrl

Parametrised pipeline hazard and stall controller for the GenshinCPU core. It replaces the fixed seven-stage control decoder. For N pipeline stages it generates per-stage write-enable, flush and disable-write vectors from prioritised hazard sources. It also detects load-after-store line conflicts against a configurable number of downstream store stages, and adds registered sequential state: the current stall cause, per-cause saturating stall counters, and a stall watchdog. It sits beside the pipeline registers and drives the I/D cache request and stall handshakes.

## Interface
- `NUM_STAGES`, 7: number of pipeline stages. Index 0 = PREIF, index NUM_STAGES-1 = WB. Legal range 5..12.
- `ST_STAGES`, 2: number of downstream store stages compared for load/store line conflicts. Legal range 1..4.
- `LINE_OFF_W`, 4: number of address bits ignored in the line compare; bits [31:LINE_OFF_W] are compared.
- `EXC_FLUSH_HI`, 4: stages 1..EXC_FLUSH_HI are flushed on an exception.
- `DH_BUB_IDX`, 3: stage that receives a bubble on a data hazard.
- `LS_BUB_IDX`, 5: stage that receives a bubble on a load/store conflict. Must be greater than DH_BUB_IDX.
- `CNT_W`, 32: width of each stall counter.
- `TIMEOUT`, 1023: number of consecutive frontend-stall cycles before the watchdog trips.

Ports:
- `clk`, in, 1: clock.
- `resetn`, in, 1: synchronous, active-low reset.
- `flush_exception`, in, 1: exception redirect.
- `i_tlb_stall`, `icache_busy`, in, 1 each: instruction-side stall sources.
- `d_tlb_stall`, `dcache_busy`, in, 1 each: data-side stall sources.
- `dh_stall`, in, 1: load-use data hazard.
- `id_imme_jump`, in, 1: J/JAL resolved in ID.
- `branch_failed`, in, 1: branch mispredict.
- `divmult_busy`, in, 1: multiply/divide unit is running.
- `mem_addr`, in, 32; `mem_ls_req`, in, 1: address and request of the MEM-stage access.
- `st_addr`, in, 32*ST_STAGES; `st_req`, in, ST_STAGES: store addresses and valids. Entry i occupies bits [32i+31:32i].
- `cnt_sel`, in, 3; `cnt_rdata`, out, CNT_W: counter read port.
- `wd_clr`, in, 1: clears the watchdog flag.
- `stage_wr`, `stage_flush`, `stage_diswr`, out, NUM_STAGES each: per-stage control vectors.
- `icache_flush`, `ireq_valid`, `dreq_valid`, `icache_stall`, `dcache_stall`, out, 1 each.
- `stall_cause`, out, 3: registered stall cause.
- `wd_trip`, out, 1: sticky watchdog flag.

## Operation
- The combinational decode is strictly prioritised, highest first: EXC > ISTALL > DSTALL > LS > DH > JUMP > BR > MD > RUN.
- Load/store conflict (LS) = mem_ls_req && OR over i of (st_req[i] && mem_addr[31:LINE_OFF_W]==st_addr_i[31:LINE_OFF_W]).
- ISTALL = i_tlb_stall|icache_busy. DSTALL = d_tlb_stall|dcache_busy.
- Per-cause outputs. Any vector bit not listed takes its RUN value.
  - RUN: stage_wr all 1. flush and diswr all 0. ireq_valid=dreq_valid=1. icache_flush and both stall outputs 0.
  - EXC: stage_wr all 1. stage_flush[1..EXC_FLUSH_HI]=1. stage_diswr[1..EXC_FLUSH_HI]=1. icache_flush=1. ireq_valid=dreq_valid=0. Both stall outputs 0.
  - ISTALL: stage_wr all 0. stage_diswr all 1. ireq_valid=0, dreq_valid=1. icache_stall=dcache_stall=1.
  - DSTALL: same as ISTALL except ireq_valid=1 and dreq_valid=0.
  - LS: stage_wr[0..LS_BUB_IDX]=0, higher stages 1. stage_flush[LS_BUB_IDX]=1. ireq_valid=dreq_valid=0. icache_stall=1.
  - DH: stage_wr[0..DH_BUB_IDX-1]=0. stage_flush[DH_BUB_IDX]=1 with stage_wr[DH_BUB_IDX]=1. icache_stall=1.
  - JUMP: stage_flush[1]=1. icache_flush=1. ireq_valid=0.
  - BR: stage_flush[1]=stage_flush[2]=1. icache_flush=1. ireq_valid=0.
  - MD: stage_wr all 0. stage_diswr all 1. icache_stall=dcache_stall=1.
- No output is ever X. Every output bit in every cause is a defined 0 or 1.
- stall_cause register encoding: 0 RUN, 1 ISTALL, 2 DSTALL, 3 LS, 4 DH, 5 MD, 6 EXC, 7 FLUSH (JUMP or BR). Each cycle it is loaded with the winning cause.
- Counters are CNT_W wide and saturate at all-ones.
  - Counter k (k=1..7) increments when the winning cause this cycle encodes to k.
  - Counter 0 counts cycles where cause is RUN.
  - cnt_rdata = counter[cnt_sel], read combinationally from the registers.
- Watchdog:
  - run_cnt increments while stage_wr[0]==0 and the cause is not EXC. It resets to 0 otherwise.
  - When run_cnt==TIMEOUT, wd_trip is set to 1 and run_cnt holds.
  - wd_trip clears only on wd_clr or reset. If wd_clr and a trip occur in the same cycle, wd_clr wins.

## Timing
- The control vectors are combinational from the inputs, with zero latency and in the same cycle. This is mandatory because the pipeline registers sample them at the next edge.
- stall_cause, the counters and wd_trip update at the clk edge, one cycle after the cause.
- While resetn=0, the combinational outputs are forced to:
  - stage_wr=0, stage_flush all 1, stage_diswr all 1;
  - ireq_valid=dreq_valid=0;
  - icache_flush=1, icache_stall=dcache_stall=0.
- At the first edge with resetn=0: stall_cause=0, all counters 0, run_cnt=0, wd_trip=0.
- If reset is asserted mid-stall, the stall ends immediately and counting restarts from 0.
- When several causes are active in one cycle, only the highest-priority cause affects the outputs and the counters.

## Test plan
- All inputs idle for 10 cycles → stage_wr=7'h7F, ireq_valid=dreq_valid=1, counter0=10, stall_cause=0.
- flush_exception together with icache_busy → exception wins: stage_flush=7'b0011110, icache_flush=1, ireq_valid=0; next cycle stall_cause=6, counter1 unchanged.
- mem_ls_req=1, mem_addr=0x80001004, st_req=2'b10, st_addr[1]=0x8000100C (same line) → LS: stage_wr=7'b1000000, stage_flush[5]=1. Change st_addr[1] to 0x80001010 → RUN.
- dh_stall for 3 cycles → stage_wr=7'b1111000, stage_flush[3]=1, icache_stall=1; counter4=3.
- divmult_busy held for TIMEOUT cycles with TIMEOUT=8 → wd_trip rises after 8 stall cycles. Assert wd_clr with divmult_busy still high → wd_trip=0 that cycle.
- Force counter3 to all-ones with CNT_W=4 and apply one more LS cycle → counter stays 4'hF. Assert resetn=0 mid-stall → stage_wr=0 and all counters 0 after the edge.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
// Pipeline hazard and stall controller. It turns prioritised hazard sources
// into per-stage write-enable, flush and disable-write vectors with zero
// latency. It also keeps registered bookkeeping: the last stall cause,
// per-cause saturating counters and a frontend-stall watchdog.
//
// Ports:
//   clk, resetn          clock, synchronous active-low reset
//   flush_exception      exception redirect (highest priority)
//   i_tlb_stall/icache_busy, d_tlb_stall/dcache_busy   I/D side stalls
//   dh_stall, id_imme_jump, branch_failed, divmult_busy hazard sources
//   mem_addr/mem_ls_req  MEM-stage access, compared against st_addr/st_req
//   cnt_sel/cnt_rdata    combinational read port of the cause counters
//   wd_clr               clears the sticky watchdog flag
//   stage_wr/stage_flush/stage_diswr   per-stage control vectors
//   icache_flush, ireq_valid, dreq_valid, icache_stall, dcache_stall
//   stall_cause          registered winning cause code
//   wd_trip              sticky watchdog flag
module pipe_hazard_ctrl #(
    parameter int NUM_STAGES   = 7,
    parameter int ST_STAGES    = 2,
    parameter int LINE_OFF_W   = 4,
    parameter int EXC_FLUSH_HI = 4,
    parameter int DH_BUB_IDX   = 3,
    parameter int LS_BUB_IDX   = 5,
    parameter int CNT_W        = 32,
    parameter int TIMEOUT      = 1023
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    flush_exception,
    input  logic                    i_tlb_stall,
    input  logic                    icache_busy,
    input  logic                    d_tlb_stall,
    input  logic                    dcache_busy,
    input  logic                    dh_stall,
    input  logic                    id_imme_jump,
    input  logic                    branch_failed,
    input  logic                    divmult_busy,
    input  logic [31:0]             mem_addr,
    input  logic                    mem_ls_req,
    input  logic [32*ST_STAGES-1:0] st_addr,
    input  logic [ST_STAGES-1:0]    st_req,
    input  logic [2:0]              cnt_sel,
    output logic [CNT_W-1:0]        cnt_rdata,
    input  logic                    wd_clr,
    output logic [NUM_STAGES-1:0]   stage_wr,
    output logic [NUM_STAGES-1:0]   stage_flush,
    output logic [NUM_STAGES-1:0]   stage_diswr,
    output logic                    icache_flush,
    output logic                    ireq_valid,
    output logic                    dreq_valid,
    output logic                    icache_stall,
    output logic                    dcache_stall,
    output logic [2:0]              stall_cause,
    output logic                    wd_trip
);

    typedef enum logic [3:0] {
        CS_RUN, CS_EXC, CS_ISTALL, CS_DSTALL, CS_LS, CS_DH, CS_JUMP, CS_BR, CS_MD
    } cause_e;

    localparam int RC_W = ($clog2(TIMEOUT + 1) < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [RC_W-1:0] RC_MAX = RC_W'(TIMEOUT);

    // Constant per-stage masks derived from the bubble/flush parameters.
    logic [NUM_STAGES-1:0] exc_mask, ls_wr_mask, dh_wr_mask, ls_bub, dh_bub, jmp_mask, br_mask;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_STAGES; gi++) begin : g_mask
            assign exc_mask[gi]   = (gi >= 1) && (gi <= EXC_FLUSH_HI);
            assign ls_wr_mask[gi] = (gi > LS_BUB_IDX);
            assign dh_wr_mask[gi] = (gi >= DH_BUB_IDX);
            assign ls_bub[gi]     = (gi == LS_BUB_IDX);
            assign dh_bub[gi]     = (gi == DH_BUB_IDX);
            assign jmp_mask[gi]   = (gi == 1);
            assign br_mask[gi]    = (gi == 1) || (gi == 2);
        end
    endgenerate

    // Line-granular load/store conflict against every downstream store stage.
    logic [ST_STAGES-1:0] ls_hit;
    generate
        for (gi = 0; gi < ST_STAGES; gi++) begin : g_ls
            assign ls_hit[gi] = st_req[gi] &&
                (mem_addr[31:LINE_OFF_W] == st_addr[32*gi+31 : 32*gi+LINE_OFF_W]);
        end
    endgenerate

    logic ls_conflict;
    assign ls_conflict = mem_ls_req && (|ls_hit);

    cause_e cause;
    always_comb begin
        cause = CS_RUN;
        if (flush_exception)                  cause = CS_EXC;
        else if (i_tlb_stall || icache_busy)  cause = CS_ISTALL;
        else if (d_tlb_stall || dcache_busy)  cause = CS_DSTALL;
        else if (ls_conflict)                 cause = CS_LS;
        else if (dh_stall)                    cause = CS_DH;
        else if (id_imme_jump)                cause = CS_JUMP;
        else if (branch_failed)               cause = CS_BR;
        else if (divmult_busy)                cause = CS_MD;
    end

    // Control vectors: start from RUN and override only what the cause changes.
    always_comb begin
        stage_wr     = '1;
        stage_flush  = '0;
        stage_diswr  = '0;
        icache_flush = 1'b0;
        ireq_valid   = 1'b1;
        dreq_valid   = 1'b1;
        icache_stall = 1'b0;
        dcache_stall = 1'b0;
        case (cause)
            CS_EXC: begin
                stage_flush  = exc_mask;
                stage_diswr  = exc_mask;
                icache_flush = 1'b1;
                ireq_valid   = 1'b0;
                dreq_valid   = 1'b0;
            end
            CS_ISTALL: begin
                stage_wr     = '0;
                stage_diswr  = '1;
                ireq_valid   = 1'b0;
                icache_stall = 1'b1;
                dcache_stall = 1'b1;
            end
            CS_DSTALL: begin
                stage_wr     = '0;
                stage_diswr  = '1;
                dreq_valid   = 1'b0;
                icache_stall = 1'b1;
                dcache_stall = 1'b1;
            end
            CS_LS: begin
                stage_wr     = ls_wr_mask;
                stage_flush  = ls_bub;
                ireq_valid   = 1'b0;
                dreq_valid   = 1'b0;
                icache_stall = 1'b1;
            end
            CS_DH: begin
                stage_wr     = dh_wr_mask;
                stage_flush  = dh_bub;
                icache_stall = 1'b1;
            end
            CS_JUMP: begin
                stage_flush  = jmp_mask;
                icache_flush = 1'b1;
                ireq_valid   = 1'b0;
            end
            CS_BR: begin
                stage_flush  = br_mask;
                icache_flush = 1'b1;
                ireq_valid   = 1'b0;
            end
            CS_MD: begin
                stage_wr     = '0;
                stage_diswr  = '1;
                icache_stall = 1'b1;
                dcache_stall = 1'b1;
            end
            default: ;
        endcase
        // Reset holds the whole pipeline flushed with no cache traffic.
        if (!resetn) begin
            stage_wr     = '0;
            stage_flush  = '1;
            stage_diswr  = '1;
            ireq_valid   = 1'b0;
            dreq_valid   = 1'b0;
            icache_flush = 1'b1;
            icache_stall = 1'b0;
            dcache_stall = 1'b0;
        end
    end

    // Jump and branch share the FLUSH code.
    logic [2:0] cause_code;
    always_comb begin
        cause_code = 3'd0;
        case (cause)
            CS_ISTALL: cause_code = 3'd1;
            CS_DSTALL: cause_code = 3'd2;
            CS_LS:     cause_code = 3'd3;
            CS_DH:     cause_code = 3'd4;
            CS_MD:     cause_code = 3'd5;
            CS_EXC:    cause_code = 3'd6;
            CS_JUMP,
            CS_BR:     cause_code = 3'd7;
            default:   cause_code = 3'd0;
        endcase
    end

    logic [2:0] stall_cause_reg;
    always_ff @(posedge clk) begin
        if (!resetn) stall_cause_reg <= 3'd0;
        else         stall_cause_reg <= cause_code;
    end
    assign stall_cause = stall_cause_reg;

    // One saturating counter per cause code; exactly one advances per cycle.
    logic [CNT_W-1:0] cnt_arr [8];
    generate
        for (gi = 0; gi < 8; gi++) begin : g_cnt
            logic [CNT_W-1:0] cnt_reg;
            always_ff @(posedge clk) begin
                if (!resetn)
                    cnt_reg <= '0;
                else if ((cause_code == 3'(gi)) && (cnt_reg != '1))
                    cnt_reg <= cnt_reg + CNT_W'(1);
            end
            assign cnt_arr[gi] = cnt_reg;
        end
    endgenerate
    assign cnt_rdata = cnt_arr[cnt_sel];

    // Watchdog: counts consecutive cycles with the frontend frozen, then
    // parks at TIMEOUT so the trip keeps reasserting while the stall lasts.
    logic [RC_W-1:0] run_cnt_reg, run_cnt_next;
    logic            wd_trip_reg, wd_stall, wd_hit;

    assign wd_stall     = !stage_wr[0] && (cause != CS_EXC);
    assign run_cnt_next = (run_cnt_reg == RC_MAX) ? run_cnt_reg : run_cnt_reg + RC_W'(1);
    assign wd_hit       = wd_stall && (run_cnt_next == RC_MAX);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            run_cnt_reg <= '0;
            wd_trip_reg <= 1'b0;
        end else begin
            run_cnt_reg <= wd_stall ? run_cnt_next : '0;
            if (wd_clr)      wd_trip_reg <= 1'b0;
            else if (wd_hit) wd_trip_reg <= 1'b1;
        end
    end
    assign wd_trip = wd_trip_reg;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl (7 stages, CNT_W=4, TIMEOUT=8).
// The driver pushes one expected record per cycle; a monitor pops it on the
// falling edge and compares the live outputs.
module tb_pipe_hazard_ctrl;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        resetn, flush_exception, i_tlb_stall, icache_busy, d_tlb_stall, dcache_busy;
    logic        dh_stall, id_imme_jump, branch_failed, divmult_busy, mem_ls_req, wd_clr;
    logic [31:0] mem_addr;
    logic [63:0] st_addr;
    logic [1:0]  st_req;
    logic [2:0]  cnt_sel;
    logic [3:0]  cnt_rdata;
    logic [6:0]  stage_wr, stage_flush, stage_diswr;
    logic        icache_flush, ireq_valid, dreq_valid, icache_stall, dcache_stall;
    logic [2:0]  stall_cause;
    logic        wd_trip;

    pipe_hazard_ctrl #(
        .NUM_STAGES(7), .ST_STAGES(2), .LINE_OFF_W(4), .EXC_FLUSH_HI(4),
        .DH_BUB_IDX(3), .LS_BUB_IDX(5), .CNT_W(4), .TIMEOUT(8)
    ) dut (
        .clk(clk), .resetn(resetn), .flush_exception(flush_exception),
        .i_tlb_stall(i_tlb_stall), .icache_busy(icache_busy),
        .d_tlb_stall(d_tlb_stall), .dcache_busy(dcache_busy),
        .dh_stall(dh_stall), .id_imme_jump(id_imme_jump), .branch_failed(branch_failed),
        .divmult_busy(divmult_busy), .mem_addr(mem_addr), .mem_ls_req(mem_ls_req),
        .st_addr(st_addr), .st_req(st_req), .cnt_sel(cnt_sel), .cnt_rdata(cnt_rdata),
        .wd_clr(wd_clr), .stage_wr(stage_wr), .stage_flush(stage_flush),
        .stage_diswr(stage_diswr), .icache_flush(icache_flush), .ireq_valid(ireq_valid),
        .dreq_valid(dreq_valid), .icache_stall(icache_stall), .dcache_stall(dcache_stall),
        .stall_cause(stall_cause), .wd_trip(wd_trip)
    );

    localparam int K_RUN = 0, K_EXC = 1, K_IST = 2, K_DST = 3, K_LS = 4;
    localparam int K_DH  = 5, K_JMP = 6, K_BR  = 7, K_MD  = 8, K_RST = 9;

    // sc = {icache_flush, ireq_valid, dreq_valid, icache_stall, dcache_stall}
    typedef struct {
        string      name;
        logic [6:0] wr, fl, dw;
        logic [4:0] sc;
        int         cause;   // -1: not checked
        int         cnt;     // -1: not checked
        int         wd;      // -1: not checked
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        flush_exception = 0; i_tlb_stall = 0; icache_busy = 0; d_tlb_stall = 0;
        dcache_busy = 0; dh_stall = 0; id_imme_jump = 0; branch_failed = 0;
        divmult_busy = 0; mem_ls_req = 0; mem_addr = '0; st_addr = '0; st_req = '0;
        wd_clr = 0;
    endtask

    task automatic expect_cyc(string nm, int kind, int cause, int cnt, int wd);
        exp_t e;
        e.name = nm; e.cause = cause; e.cnt = cnt; e.wd = wd;
        case (kind)
            K_EXC:   begin e.wr = 7'h7F; e.fl = 7'h1E; e.dw = 7'h1E; e.sc = 5'b10000; end
            K_IST:   begin e.wr = 7'h00; e.fl = 7'h00; e.dw = 7'h7F; e.sc = 5'b00111; end
            K_DST:   begin e.wr = 7'h00; e.fl = 7'h00; e.dw = 7'h7F; e.sc = 5'b01011; end
            K_LS:    begin e.wr = 7'h40; e.fl = 7'h20; e.dw = 7'h00; e.sc = 5'b00010; end
            K_DH:    begin e.wr = 7'h78; e.fl = 7'h08; e.dw = 7'h00; e.sc = 5'b01110; end
            K_JMP:   begin e.wr = 7'h7F; e.fl = 7'h02; e.dw = 7'h00; e.sc = 5'b10100; end
            K_BR:    begin e.wr = 7'h7F; e.fl = 7'h06; e.dw = 7'h00; e.sc = 5'b10100; end
            K_MD:    begin e.wr = 7'h00; e.fl = 7'h00; e.dw = 7'h7F; e.sc = 5'b01111; end
            K_RST:   begin e.wr = 7'h00; e.fl = 7'h7F; e.dw = 7'h7F; e.sc = 5'b10000; end
            default: begin e.wr = 7'h7F; e.fl = 7'h00; e.dw = 7'h00; e.sc = 5'b01100; end
        endcase
        exp_q.push_back(e);
    endtask

    task automatic chk(string nm, string fld, logic [31:0] got, logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s %s: got %0h expected %0h", nm, fld, got, want);
        end
    endtask

    // Monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk(e.name, "stage_wr", 32'(stage_wr), 32'(e.wr));
                chk(e.name, "stage_flush", 32'(stage_flush), 32'(e.fl));
                chk(e.name, "stage_diswr", 32'(stage_diswr), 32'(e.dw));
                chk(e.name, "scalars", 32'({icache_flush, ireq_valid, dreq_valid,
                                            icache_stall, dcache_stall}), 32'(e.sc));
                if (e.cause >= 0) chk(e.name, "stall_cause", 32'(stall_cause), e.cause);
                if (e.cnt >= 0)   chk(e.name, "cnt_rdata", 32'(cnt_rdata), e.cnt);
                if (e.wd >= 0)    chk(e.name, "wd_trip", 32'(wd_trip), e.wd);
                $display("txn %-10s wr=%h fl=%h dw=%h cause=%0d cnt[%0d]=%0d wd=%0b",
                         e.name, stage_wr, stage_flush, stage_diswr, stall_cause,
                         cnt_sel, cnt_rdata, wd_trip);
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    // Driver
    initial begin
        resetn = 0; cnt_sel = 0; idle_inputs();
        tick(); tick();
        expect_cyc("reset", K_RST, 0, 0, 0);

        // Idle: counter0 tracks RUN cycles
        for (int i = 0; i <= 10; i++) begin
            tick(); resetn = 1; cnt_sel = 0;
            expect_cyc("idle", K_RUN, 0, i, 0);
        end

        // Exception beats icache stall
        tick(); flush_exception = 1; icache_busy = 1; cnt_sel = 1;
        expect_cyc("exc", K_EXC, 0, 0, 0);
        tick(); idle_inputs();
        expect_cyc("exc_after", K_RUN, 6, 0, -1);
        tick(); cnt_sel = 6;
        expect_cyc("exc_cnt6", K_RUN, 0, 1, -1);

        // Load/store line conflict
        tick(); cnt_sel = 3; mem_ls_req = 1; mem_addr = 32'h8000_1004;
        st_req = 2'b10; st_addr = {32'h8000_100C, 32'h0};
        expect_cyc("ls_hit1", K_LS, 0, 0, -1);
        tick(); st_addr = {32'h8000_1010, 32'h0};
        expect_cyc("ls_miss", K_RUN, 3, 1, -1);
        tick(); st_addr = {32'h8000_100C, 32'h0}; st_req = 2'b01;
        expect_cyc("ls_noreq", K_RUN, 0, 1, -1);
        tick(); st_addr = {32'h8000_100C, 32'h8000_100F};
        expect_cyc("ls_hit0", K_LS, 0, 1, -1);
        tick(); mem_ls_req = 0;
        expect_cyc("ls_noacc", K_RUN, 3, 2, -1);
        tick(); idle_inputs();

        // Data hazard for 3 cycles
        for (int i = 0; i < 3; i++) begin
            tick(); dh_stall = 1; cnt_sel = 4;
            expect_cyc("dh", K_DH, (i == 0) ? 0 : 4, i, -1);
        end
        tick(); dh_stall = 0;
        expect_cyc("dh_done", K_RUN, 4, 3, -1);

        // Priority chain: JUMP > BR > MD, DSTALL, ISTALL
        tick(); id_imme_jump = 1; branch_failed = 1; divmult_busy = 1; cnt_sel = 7;
        expect_cyc("jump", K_JMP, 0, 0, -1);
        tick(); id_imme_jump = 0;
        expect_cyc("branch", K_BR, 7, 1, -1);
        tick(); branch_failed = 0;
        expect_cyc("md", K_MD, 7, 2, -1);
        tick(); divmult_busy = 0; d_tlb_stall = 1; dh_stall = 1; cnt_sel = 5;
        expect_cyc("dstall", K_DST, 5, 1, -1);
        tick(); d_tlb_stall = 0; dh_stall = 0; i_tlb_stall = 1; dcache_busy = 1; cnt_sel = 2;
        expect_cyc("istall", K_IST, 2, 1, -1);
        tick(); idle_inputs(); cnt_sel = 1;
        expect_cyc("run_c1", K_RUN, 1, 1, 0);

        // Watchdog with TIMEOUT=8
        for (int i = 0; i < 10; i++) begin
            tick(); divmult_busy = 1;
            expect_cyc("wd_md", K_MD, -1, -1, (i >= 8) ? 1 : 0);
        end
        tick(); wd_clr = 1;
        expect_cyc("wd_clr", K_MD, -1, -1, 1);
        tick(); wd_clr = 0;
        expect_cyc("wd_cleared", K_MD, -1, -1, 0);
        tick();
        expect_cyc("wd_retrip", K_MD, -1, -1, 1);
        tick(); divmult_busy = 0;
        expect_cyc("wd_sticky", K_RUN, -1, -1, 1);
        tick(); wd_clr = 1;
        expect_cyc("wd_sticky2", K_RUN, -1, -1, 1);
        tick(); wd_clr = 0;
        expect_cyc("wd_off", K_RUN, -1, -1, 0);

        // Reset, then saturate counter3, then reset mid-stall
        tick(); resetn = 0;
        expect_cyc("rst2", K_RST, -1, -1, -1);
        tick(); resetn = 1; cnt_sel = 3;
        expect_cyc("rst2_done", K_RUN, 0, 0, 0);
        for (int i = 0; i < 18; i++) begin
            tick(); mem_ls_req = 1; mem_addr = 32'h8000_1004;
            st_req = 2'b10; st_addr = {32'h8000_100C, 32'h0};
            expect_cyc("ls_sat", K_LS, (i == 0) ? 0 : 3, (i > 15) ? 15 : i, (i >= 8) ? 1 : 0);
        end
        tick(); resetn = 0;
        expect_cyc("rst_mid", K_RST, 3, 15, 1);
        tick();
        expect_cyc("rst_mid2", K_RST, 0, 0, 0);
        tick(); resetn = 1;
        expect_cyc("ls_resume", K_LS, 0, 0, 0);
        tick(); idle_inputs();
        expect_cyc("run_after", K_RUN, 3, 1, 0);
        tick(); cnt_sel = 0;
        expect_cyc("cnt0_after", K_RUN, 0, 1, 0);

        // Let the monitor drain
        tick(); tick();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending records expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
